// File: rtl/game_pkg.sv
// game_pkg: shape encodings, code/feedback types and the base-6 candidate step
package game_pkg;
    localparam int NUM_POSITIONS = 4;
    typedef enum logic [2:0] {
        SH_NONE = 3'd0,
        SH_T    = 3'd1,
        SH_C    = 3'd2,
        SH_O    = 3'd3,
        SH_D    = 3'd4,
        SH_I    = 3'd5,
        SH_Z    = 3'd6
    } shape_t;
    typedef shape_t [NUM_POSITIONS-1:0] code_t;
    typedef struct packed {
        logic [3:0] znarly;
        logic [3:0] zood;
    } feedback_t;
    // Returns {carry_out, next_code}; each digit runs 1..6, position 0 least significant
    function automatic logic [12:0] next_code(input logic [11:0] c);
        logic [12:0] r;
        logic cy;
        r = '0;
        cy = 1'b1;
        for (int p = 0; p < NUM_POSITIONS; p++) begin
            r[3*p +: 3] = !cy ? c[3*p +: 3] : (c[3*p +: 3] == 3'd6) ? 3'd1 : c[3*p +: 3] + 3'd1;
            cy = cy && (c[3*p +: 3] == 3'd6);
        end
        r[12] = cy;
        return r;
    endfunction
endpackage

// File: rtl/code_scorer.sv
// code_scorer: combinational Znarly/Zood grading of two codes
module code_scorer
    import game_pkg::*;
(
    input  code_t     a,
    input  code_t     b,
    output feedback_t fb
);
    logic [3:0] exact, common, ca, cb;
    always_comb begin
        exact = '0;
        common = '0;
        ca = '0;
        cb = '0;
        for (int p = 0; p < NUM_POSITIONS; p++)
            exact = exact + 4'(a[p] == b[p]);
        for (int s = 1; s <= 6; s++) begin
            ca = '0;
            cb = '0;
            for (int p = 0; p < NUM_POSITIONS; p++) begin
                ca = ca + 4'(a[p] == shape_t'(s));
                cb = cb + 4'(b[p] == shape_t'(s));
            end
            common = common + ((ca < cb) ? ca : cb);
        end
        fb.znarly = exact;
        fb.zood = common - exact;
    end
endmodule

// File: rtl/code_breaker.sv
// code_breaker: issues the first code, in enumeration order, consistent with all feedback so far
module code_breaker
    import game_pkg::*;
#(
    parameter int MAX_ROUNDS       = 10,
    parameter int GRADE_LOW_CYCLES = 2
) (
    input  logic        CLOCK_50,
    input  logic        reset_L,
    input  logic        start,
    output logic [11:0] Guess,
    output logic        Grade_it_L,
    input  logic        grade_valid,
    input  logic [3:0]  Znarly,
    input  logic [3:0]  Zood,
    output logic        busy,
    output logic        solved,
    output logic        fail,
    output logic [3:0]  round_count
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DONE, FAIL} state_t;
    state_t state;
    logic [11:0] cand;
    logic [3:0] hist_idx;
    logic [7:0] low_cnt;
    logic [11:0] hist_guess [MAX_ROUNDS];
    feedback_t hist_fb [MAX_ROUNDS];
    feedback_t score;
    code_t cand_code, hist_code;
    logic [12:0] cand_next;
    assign cand_code = code_t'(cand);
    assign hist_code = code_t'(hist_guess[hist_idx]);
    assign cand_next = next_code(cand);
    code_scorer u_scorer (.a(cand_code), .b(hist_code), .fb(score));
    always_ff @(posedge CLOCK_50 or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
            cand <= 12'o1111;
            Guess <= '0;
            Grade_it_L <= 1'b1;
            busy <= 1'b0;
            solved <= 1'b0;
            fail <= 1'b0;
            round_count <= '0;
            hist_idx <= '0;
            low_cnt <= '0;
            for (int i = 0; i < MAX_ROUNDS; i++) begin
                hist_guess[i] <= '0;
                hist_fb[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE, FAIL: if (start) begin
                    cand <= 12'o1111;
                    hist_idx <= '0;
                    round_count <= '0;
                    solved <= 1'b0;
                    fail <= 1'b0;
                    busy <= 1'b1;
                    state <= CHECK;
                end
                CHECK: if (round_count != 4'd0 && score != hist_fb[hist_idx]) begin
                    hist_idx <= '0;
                    cand <= cand_next[11:0];
                    if (cand_next[12]) begin
                        state <= FAIL;
                        busy <= 1'b0;
                        fail <= 1'b1;
                    end
                end else if (round_count == 4'd0 || hist_idx == round_count - 4'd1) begin
                    state <= ISSUE;
                    Guess <= cand;
                    low_cnt <= '0;
                end else begin
                    hist_idx <= hist_idx + 4'd1;
                end
                ISSUE: if (low_cnt == 8'(GRADE_LOW_CYCLES)) begin
                    Grade_it_L <= 1'b1;
                    state <= WAIT;
                end else begin
                    Grade_it_L <= 1'b0;
                    low_cnt <= low_cnt + 8'd1;
                end
                WAIT: if (grade_valid) begin
                    hist_guess[round_count] <= Guess;
                    hist_fb[round_count] <= '{znarly: Znarly, zood: Zood};
                    round_count <= round_count + 4'd1;
                    hist_idx <= '0;
                    cand <= cand_next[11:0];
                    // cand still equals Guess here, so stepping it skips the graded code
                    if (Znarly == 4'd4) begin
                        state <= DONE;
                        busy <= 1'b0;
                        solved <= 1'b1;
                    end else if (round_count + 4'd1 == 4'(MAX_ROUNDS) || cand_next[12]) begin
                        state <= FAIL;
                        busy <= 1'b0;
                        fail <= 1'b1;
                    end else begin
                        state <= CHECK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_code_breaker.sv
// tb_code_breaker: closed-loop check of code_breaker against a brute-force consistency model
module tb_code_breaker;
    localparam int MAXR = 10;
    localparam int GLC = 2;
    localparam logic [11:0] TTTT = 12'b001_001_001_001;
    localparam logic [11:0] CCCC = 12'b010_010_010_010;
    localparam logic [11:0] IZDT = 12'b101_110_100_001;
    logic CLOCK_50 = 1'b0;
    logic reset_L, start, grade_valid;
    logic [3:0] Znarly, Zood;
    logic [11:0] Guess, g1;
    logic Grade_it_L, busy, solved, fail, gl1, busy1, solved1, fail1;
    logic [3:0] round_count, rc1;
    int n_tests = 0;
    int n_fail = 0;
    logic [11:0] hg[$];
    logic [7:0] hf[$];

    code_breaker #(.MAX_ROUNDS(MAXR), .GRADE_LOW_CYCLES(GLC)) dut (
        .CLOCK_50(CLOCK_50), .reset_L(reset_L), .start(start), .Guess(Guess),
        .Grade_it_L(Grade_it_L), .grade_valid(grade_valid), .Znarly(Znarly), .Zood(Zood),
        .busy(busy), .solved(solved), .fail(fail), .round_count(round_count));
    code_breaker #(.MAX_ROUNDS(1), .GRADE_LOW_CYCLES(GLC)) dut1 (
        .CLOCK_50(CLOCK_50), .reset_L(reset_L), .start(start), .Guess(g1),
        .Grade_it_L(gl1), .grade_valid(grade_valid), .Znarly(Znarly), .Zood(Zood),
        .busy(busy1), .solved(solved1), .fail(fail1), .round_count(rc1));

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] idx2code(input int idx);
        logic [11:0] c;
        int v = idx;
        for (int p = 0; p < 4; p++) begin
            c[3*p +: 3] = 3'(v % 6 + 1);
            v = v / 6;
        end
        return c;
    endfunction

    function automatic logic [7:0] ref_score(input logic [11:0] a, input logic [11:0] b);
        int ca[8] = '{default: 0};
        int cb[8] = '{default: 0};
        int zn = 0;
        int com = 0;
        for (int p = 0; p < 4; p++) begin
            if (a[3*p +: 3] == b[3*p +: 3]) zn++;
            ca[a[3*p +: 3]]++;
            cb[b[3*p +: 3]]++;
        end
        for (int s = 1; s <= 6; s++) com += (ca[s] < cb[s]) ? ca[s] : cb[s];
        return {4'(zn), 4'(com - zn)};
    endfunction

    function automatic int next_cons(input int from);
        for (int i = from; i < 1296; i++) begin
            logic [11:0] c = idx2code(i);
            bit ok = 1;
            foreach (hg[k]) if (ref_score(c, hg[k]) != hf[k]) ok = 0;
            if (ok) return i;
        end
        return -1;
    endfunction

    task automatic chk_reset(input string tag);
        chk(tag, {Guess, Grade_it_L, busy, solved, fail, round_count}, {12'd0, 1'b1, 3'b000, 4'd0});
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset_L = 0;
        @(negedge CLOCK_50);
        reset_L = 1;
    endtask

    task automatic pulse_start();
        @(negedge CLOCK_50);
        start = 1;
        @(negedge CLOCK_50);
        start = 0;
    endtask

    task automatic reply(input logic [3:0] zn, input logic [3:0] zo);
        @(negedge CLOCK_50);
        grade_valid = 1;
        Znarly = zn;
        Zood = zo;
        @(negedge CLOCK_50);
        grade_valid = 0;
    endtask

    task automatic get_guess(output logic [11:0] g, output bit ok, input bit stray);
        int n = 0;
        int low = 0;
        ok = 0;
        g = '0;
        while (Grade_it_L && n < 20000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("grade_req_seen", n < 20000, 1);
        if (n >= 20000) return;
        g = Guess;
        while (!Grade_it_L && low < 10) begin
            if (stray && low == 0) begin
                grade_valid = 1;
                Znarly = 4;
                Zood = 0;
            end
            @(negedge CLOCK_50);
            grade_valid = 0;
            low++;
        end
        chk("grade_low_len", low, GLC);
        ok = 1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic play(input logic [11:0] master, input bit stray);
        int idx = 0;
        int rounds = 0;
        bit fin = 0;
        bit ok;
        logic [11:0] g, exp;
        logic [7:0] fb = 8'h00;
        hg.delete();
        hf.delete();
        pulse_start();
        while (!fin) begin
            exp = idx2code(idx);
            get_guess(g, ok, stray);
            chk("loop_guess", g, exp);
            if (!ok) break;
            fb = ref_score(exp, master);
            hg.push_back(exp);
            hf.push_back(fb);
            reply(fb[7:4], fb[3:0]);
            rounds++;
            if (fb[7:4] == 4 || rounds == MAXR) fin = 1;
            else begin
                idx = next_cons(idx + 1);
                if (idx < 0) fin = 1;
            end
        end
        wait_idle();
        chk("loop_solved", solved, fb[7:4] == 4);
        chk("loop_fail", fail, fb[7:4] != 4);
        chk("loop_rounds", round_count, rounds);
        if (fb[7:4] == 4) chk("loop_final_guess", Guess, master);
    endtask

    initial begin
        logic [11:0] g, m;
        bit ok, gl_seen;
        int n;
        reset_L = 1;
        start = 0;
        grade_valid = 0;
        Znarly = 0;
        Zood = 0;
        #3 reset_L = 0;
        #1 chk_reset("reset_values");
        @(negedge CLOCK_50);
        reset_L = 1;
        // stray grade_valid while idle
        reply(4, 0);
        @(negedge CLOCK_50);
        chk("stray_idle", {busy, solved, fail, round_count}, 0);
        // immediate solve, with a stray strobe inside the low window
        pulse_start();
        @(negedge CLOCK_50);
        chk("first_guess", Guess, TTTT);
        get_guess(g, ok, 1);
        chk("first_guess_busy", busy, 1);
        reply(4, 0);
        chk("solve_now", {solved, busy, fail, round_count}, {3'b100, 4'd1});
        // 0/0 to TTTT leads to CCCC, then reset during WAIT
        pulse_start();
        get_guess(g, ok, 0);
        chk("t_guess", g, TTTT);
        reply(0, 0);
        get_guess(g, ok, 0);
        chk("c_guess", g, CCCC);
        chk("c_rounds", round_count, 1);
        #2 reset_L = 0;
        #1 chk_reset("reset_in_wait");
        @(negedge CLOCK_50);
        reset_L = 1;
        // reset inside the Grade_it_L low window
        pulse_start();
        n = 0;
        while (Grade_it_L && n < 50) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("low_window_seen", Grade_it_L, 0);
        #2 reset_L = 0;
        #1 chk_reset("reset_in_low");
        @(negedge CLOCK_50);
        reset_L = 1;
        // closed loop against fixed and random masters
        play(IZDT, 0);
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 4; p++) m[3*p +: 3] = 3'($urandom_range(1, 6));
            do_reset();
            play(m, 1'($urandom_range(0, 1)));
        end
        // impossible feedback exhausts the search
        do_reset();
        pulse_start();
        get_guess(g, ok, 0);
        chk("imp_first", g, TTTT);
        reply(0, 1);
        n = 0;
        gl_seen = 0;
        while (!fail && n < 1400) begin
            @(negedge CLOCK_50);
            n++;
            if (!Grade_it_L) gl_seen = 1;
        end
        chk("imp_fail", fail, 1);
        chk("imp_latency", n <= 1300, 1);
        chk("imp_grade_high", gl_seen, 0);
        // single-round instance fails after one wrong guess and restarts cleanly
        do_reset();
        pulse_start();
        get_guess(g, ok, 0);
        reply(1, 0);
        chk("m1_end", {fail1, busy1, solved1, rc1}, {3'b100, 4'd1});
        pulse_start();
        chk("m1_restart", {fail1, busy1, rc1}, {2'b01, 4'd0});
        @(negedge CLOCK_50);
        chk("m1_restart_guess", g1, TTTT);
        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
